// File: rtl/seq_div_8x4.sv
// seq_div_8x4: sequential radix-2 restoring divider, 8-bit dividend / 4-bit divisor.
// One quotient bit per clock; valid/ready handshake on operands and result.
// Optional feature macro: DIV_ZERO_DETECT_EN (divide-by-zero short cut and flag).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor     unsigned operands N (8b) and D (4b)
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   quotient, remainder   registered Q (8b) and R (4b), updated on DONE entry
//   div_zero              registered D==0 flag (tied 0 without DIV_ZERO_DETECT_EN)
module seq_div_8x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero
);

    localparam int unsigned NW = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] n_q, n_d;            // dividend shifts out, quotient bits shift in
    logic [DW-1:0] dvsr_q, dvsr_d;
    logic [DW-1:0] p_q, p_d;            // partial remainder; always < D so 4 bits hold it
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [NW-1:0] quotient_q, quotient_d;
    logic [DW-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
    logic          div_zero_q, div_zero_d;
`endif

    logic [DW:0]   p_shift;
    logic          take;
    logic [DW-1:0] p_step;
    logic [NW-1:0] n_step;

    // One restoring step: widen by one bit so the compare sees the carry-out bit.
    always_comb begin
        p_shift = {p_q, n_q[NW-1]};
        take    = (p_shift >= {1'b0, dvsr_q});
        // When take is set the difference is < D, so 4-bit subtraction is exact.
        p_step  = take ? (p_shift[DW-1:0] - dvsr_q) : p_shift[DW-1:0];
        n_step  = {n_q[NW-2:0], take};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        dvsr_d      = dvsr_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d  = div_zero_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d        = dividend;
                    dvsr_d     = divisor;
                    p_d        = '0;
                    cnt_d      = '0;
                    state_d    = CALC;
                    in_ready_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                    // Zero divisor bypasses the iterations entirely.
                    if (divisor == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '1;
                        div_zero_d  = 1'b1;
                    end
`endif
                end
            end

            CALC: begin
                p_d   = p_step;
                n_d   = n_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == '1) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = n_step;
                    remainder_d = p_step;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_d  = 1'b0;
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            dvsr_q      <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            dvsr_q      <= dvsr_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero  = div_zero_q;
`else
    assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_8x4.sv
// Self-checking bench for seq_div_8x4: directed vector table, latency,
// backpressure, divide-by-zero, mid-operation reset and an exhaustive
// back-to-back sweep with random result stalls, all through a scoreboard.
module tb_seq_div_8x4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    always #5 clk = ~clk;

    seq_div_8x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } res_t;

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    res_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_seen = 0;
    bit   stall_en = 1'b0;

`ifdef DIV_ZERO_DETECT_EN
    localparam int  DIV0_LAT = 1;
    localparam logic [3:0] DIV0_R = 4'hF;
    localparam logic DIV0_DZ = 1'b1;
`else
    localparam int  DIV0_LAT = 8;
    localparam logic [3:0] DIV0_R = 4'h4;   // N[3:0] of 100
    localparam logic DIV0_DZ = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard: a result is consumed on the edge after a negedge that sees valid&&ready.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            n_seen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_extra: unexpected result q=0x%0h r=0x%0h", quotient, remainder);
            end else begin
                e = sb.pop_front();
                check("res_q", 32'(quotient), 32'(e.q));
                check("res_r", 32'(remainder), 32'(e.r));
                check("res_dz", 32'(div_zero), 32'(e.dz));
            end
        end
    end

    // Present operands until accepted; optionally record the expected result.
    task automatic send(input logic [7:0] n, input logic [3:0] d, input bit push, input res_t e);
        int guard = 0;
        dividend = n;
        divisor  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        @(negedge clk);
        while (sb.size() != 0 && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        if (sb.size() != 0) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    // Accept an operation with out_ready low and count edges until out_valid.
    task automatic lat_check(input string name, input logic [7:0] n, input logic [3:0] d,
                             input int exp_lat);
        res_t none = '{8'h00, 4'h0, 1'b0};
        int lat = 0;
        send(n, d, 1'b0, none);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, 32'(lat), 32'(exp_lat));
    endtask

    function automatic res_t model(input int n, input int d);
        res_t r;
        r.q  = 8'(n / d);
        r.r  = 4'(n % d);
        r.dz = 1'b0;
        return r;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        res_t none = '{8'h00, 4'h0, 1'b0};
        int   seen0;

        vecs[0] = '{8'd200, 4'd7,  8'h1C, 4'h4, 1'b0};
        vecs[1] = '{8'd255, 4'd15, 8'h11, 4'h0, 1'b0};
        vecs[2] = '{8'd0,   4'd3,  8'h00, 4'h0, 1'b0};
        vecs[3] = '{8'd50,  4'd6,  8'h08, 4'h2, 1'b0};
        vecs[4] = '{8'd255, 4'd1,  8'hFF, 4'h0, 1'b0};
        vecs[5] = '{8'd7,   4'd15, 8'h00, 4'h7, 1'b0};
        vecs[6] = '{8'd128, 4'd2,  8'h40, 4'h0, 1'b0};
        vecs[7] = '{8'd100, 4'd0,  8'hFF, DIV0_R, DIV0_DZ};

        in_valid  = 1'b0;
        dividend  = 8'h00;
        divisor   = 4'h0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'h00);
        check("rst_remainder", 32'(remainder), 32'h0);
        check("rst_div_zero", 32'(div_zero), 32'd0);

        // Directed vector table, back to back.
        for (int i = 0; i < 8; i++)
            send(vecs[i].n, vecs[i].d, 1'b1, '{vecs[i].q, vecs[i].r, vecs[i].dz});
        drain("table_drain");

        // Latency and backpressure on 200/7.
        out_ready = 1'b0;
        lat_check("lat_200_7", 8'd200, 4'd7, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 8'd9;
            divisor  = 4'd3;
            @(posedge clk);
            #1;
            check("bp_q", 32'(quotient), 32'h1C);
            check("bp_r", 32'(remainder), 32'h4);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        sb.push_back('{8'h1C, 4'h4, 1'b0});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("bp_ignored_input", 32'(out_valid), 32'd0);

        // Divide by zero, then a normal op to confirm the flag clears.
        out_ready = 1'b0;
        lat_check("lat_div0", 8'd100, 4'd0, DIV0_LAT);
        sb.push_back('{8'hFF, DIV0_R, DIV0_DZ});
        out_ready = 1'b1;
        drain("div0_drain");
        send(8'd9, 4'd3, 1'b1, '{8'h03, 4'h0, 1'b0});
        drain("after_div0_drain");

        // Reset during iteration 4 of 200/7 aborts it.
        send(8'd200, 4'd7, 1'b0, none);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'h00);
        check("abort_remainder", 32'(remainder), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        send(8'd50, 4'd6, 1'b1, '{8'h08, 4'h2, 1'b0});
        drain("abort_drain");

        // Exhaustive sweep of all N with nonzero D under random result stalls.
        seen0    = n_seen;
        stall_en = 1'b1;
        fork
            begin
                while (stall_en) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 256; n++)
            for (int d = 1; d < 16; d++)
                send(8'(n), 4'(d), 1'b1, model(n, d));
        drain("sweep_drain");
        stall_en = 1'b0;
        repeat (3) @(posedge clk);
        out_ready = 1'b1;
        check("sweep_count", 32'(n_seen - seen0), 32'd3840);
        check("sweep_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
